// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drain-side consumer for the 8-bit synchronous FIFO. Whenever the FIFO is
// non-empty and transmission is enabled, one word is popped and serialised
// onto a UART-style line: start bit, data bits LSB first, optional even
// parity, then STOP_BITS stop bits.
//
// Optional feature macro: FIFO_UART_TX_PARITY_EN
//   defined   -> an even-parity bit is sent between the last data bit and
//                the stop bit(s)
//   undefined -> no parity state or parity logic is built
//
// Parameters:
//   DATA_WIDTH    FIFO word width and data bits per frame
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-low reset (0 = reset)
//   enable        1 = permitted to start new frames
//   fifo_empty    FIFO empty flag
//   fifo_data     FIFO read data, valid the cycle after fifo_read_en
//   fifo_read_en  FIFO pop strobe, one cycle per byte
//   tx            serial line, idle high
//   busy          high whenever the FSM is not idle
//   byte_done     one-cycle pulse on the last stop-bit cycle
//   tx_count      frames completed, wraps at 16 bits
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done,
    output logic [15:0]           tx_count
);

    localparam int BAUD_W    = 16;
    localparam int BIT_CNT_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        STOP   = 3'd6
    } state_t;
`endif

    state_t                 state_reg,    state_next;
    logic [BAUD_W-1:0]      baud_reg,     baud_next;
    logic [BIT_CNT_W-1:0]   bit_reg,      bit_next;
    logic [DATA_WIDTH-1:0]  shift_reg,    shift_next;
    logic [15:0]            tx_count_reg, tx_count_next;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                   parity_reg,   parity_next;
`endif

    logic                   bit_end;
    logic                   more_data;
    logic [DATA_WIDTH-1:0]  shift_dn;

    // Last cycle of the current serial bit.
    assign bit_end   = (baud_reg == BAUD_LAST);
    // Another frame may start straight from the last stop cycle.
    assign more_data = enable && !fifo_empty;

    // Shift register moved one place towards the LSB, zero-filled at the top.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
            if (gi == DATA_WIDTH - 1) begin : g_top
                assign shift_dn[gi] = 1'b0;
            end else begin : g_mid
                assign shift_dn[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            tx_count_reg <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            tx_count_reg <= tx_count_next;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        tx_count_next = tx_count_reg;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next   = parity_reg;
`endif
        fifo_read_en  = 1'b0;
        tx            = 1'b1;
        busy          = 1'b1;
        byte_done     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (more_data) begin
                    state_next = POP;
                end
            end
            POP: begin
                fifo_read_en = 1'b1;
                state_next   = LOAD;
            end
            LOAD: begin
                // FIFO output was registered on the POP edge; capture it now.
                shift_next = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_next = ^fifo_data;
`endif
                baud_next  = '0;
                bit_next   = '0;
                state_next = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                tx = shift_reg[0];
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = shift_dn;
                    if (bit_reg == DATA_LAST) begin
                        bit_next = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                tx = parity_reg;
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_reg == STOP_LAST) begin
                        byte_done     = 1'b1;
                        tx_count_next = tx_count_reg + 16'd1;
                        bit_next      = '0;
                        state_next    = more_data ? POP : IDLE;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx_count = tx_count_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4. A small FIFO model
// feeds the DUT; every byte pushed into it is also pushed onto an expected
// queue. A line monitor decodes each frame from tx, checks bit timing,
// start/parity/stop bits and the byte_done position, and compares the data
// against the front of the expected queue.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int DW   = 8;
    localparam int CPB  = 4;
    localparam int STOP = 1;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR  = 1;
`else
    localparam int PAR  = 0;
`endif
    localparam int NBITS = 1 + DW + PAR + STOP;
    localparam int FL    = NBITS * CPB;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_read_en;
    logic          tx;
    logic          busy;
    logic          byte_done;
    logic [15:0]   tx_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (STOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read_en (fifo_read_en),
        .tx           (tx),
        .busy         (busy),
        .byte_done    (byte_done),
        .tx_count     (tx_count)
    );

    // ---------------- FIFO model (registered read data) ----------------
    logic [DW-1:0] fifo_mem [0:63];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic [DW-1:0] exp_q [$];

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_read_en && !fifo_empty) begin
            fifo_data <= fifo_mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [DW-1:0] b);
        fifo_mem[wr_ptr % 64] = b;
        wr_ptr++;
        exp_q.push_back(b);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- line monitor ----------------
    int   cyc = 0;
    int   pop_cnt = 0;
    int   frame_cnt = 0;
    int   pop_cyc [$];
    int   done_cyc [$];
    int   start_cyc [$];
    bit   in_frame = 1'b0;
    int   fcyc = 0;
    int   bd_cnt = 0;
    int   bd_pos = -1;
    logic fr_tx [0:FL-1];

    task automatic finish_frame();
        logic [NBITS-1:0] bits;
        logic [DW-1:0]    data;
        logic [DW-1:0]    exp;
        logic             glitch;
        glitch = 1'b0;
        for (int b = 0; b < NBITS; b++) begin
            bits[b] = fr_tx[b*CPB];
            for (int k = 1; k < CPB; k++) begin
                if (fr_tx[b*CPB+k] !== bits[b]) glitch = 1'b1;
            end
        end
        data = bits[DW:1];
        check("sb_nonempty", 32'(exp_q.size() > 0), 1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("bit_stable", 32'(glitch), 0);
        check("start_bit", 32'(bits[0]), 0);
        check("data", 32'(data), 32'(exp));
`ifdef FIFO_UART_TX_PARITY_EN
        check("parity", 32'(bits[DW+1]), 32'(^exp));
`endif
        for (int s = 0; s < STOP; s++) begin
            check("stop_bit", 32'(bits[NBITS-1-s]), 1);
        end
        check("byte_done_cnt", bd_cnt, 1);
        check("byte_done_pos", bd_pos, FL - 1);
        $display("frame %0d: byte 0x%02h expected 0x%02h start_cycle %0d", frame_cnt, data, exp,
                 start_cyc[start_cyc.size()-1]);
        frame_cnt++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (fifo_read_en === 1'b1) begin
                pop_cyc.push_back(cyc);
                pop_cnt++;
            end
            if (byte_done === 1'b1) done_cyc.push_back(cyc);
            if (in_frame && busy !== 1'b1) begin
                $display("frame %0d: aborted at frame cycle %0d", frame_cnt, fcyc);
                in_frame = 1'b0;
            end else if (in_frame || (busy === 1'b1 && tx === 1'b0)) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    fcyc     = 0;
                    bd_cnt   = 0;
                    bd_pos   = -1;
                    start_cyc.push_back(cyc);
                end
                fr_tx[fcyc] = tx;
                if (byte_done === 1'b1) begin
                    bd_cnt++;
                    bd_pos = fcyc;
                end
                if (fcyc == FL - 1) begin
                    finish_frame();
                    in_frame = 1'b0;
                end else begin
                    fcyc++;
                end
            end
        end
    end

    // Waits (bounded) for the next byte_done pulse.
    task automatic wait_done(input string tag);
        for (int i = 0; i < 4 * FL; i++) begin
            @(negedge clk);
            if (byte_done === 1'b1) break;
        end
        check(tag, 32'(byte_done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // 1: reset held with work pending
        reset  = 1'b0;
        enable = 1'b1;
        push(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx", 32'(tx), 1);
            check("rst_read_en", 32'(fifo_read_en), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_tx_count", 32'(tx_count), 0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("first_pop", 32'(fifo_read_en), 1);

        // 2: single byte 0xA5
        wait_done("done_a5");
        @(negedge clk);
        check("a5_busy", 32'(busy), 0);
        check("a5_tx_count", 32'(tx_count), 1);
        check("a5_pops", pop_cnt, 1);

        // 3: back-to-back 0x00, 0xFF
        push(8'h00);
        push(8'hFF);
        wait_done("done_00");
        wait_done("done_ff");
        @(negedge clk);
        check("b2b_pop_after_stop", pop_cyc[2] - done_cyc[1], 1);
        check("b2b_start_spacing", start_cyc[2] - start_cyc[1], FL + 2);
        check("b2b_tx_count", 32'(tx_count), 3);
        check("b2b_busy", 32'(busy), 0);

        // 4: enable dropped during DATA of 0x3C with two more bytes queued
        push(8'h3C);
        push(8'h11);
        push(8'h22);
        repeat (12) @(negedge clk);
        enable = 1'b0;
        wait_done("done_3c");
        repeat (50) @(negedge clk);
        check("dis_pops", pop_cnt, 4);
        check("dis_busy", 32'(busy), 0);
        check("dis_tx_count", 32'(tx_count), 4);

        // Re-enable: the two queued bytes drain
        enable = 1'b1;
        wait_done("done_11");
        wait_done("done_22");
        @(negedge clk);
        check("drain_tx_count", 32'(tx_count), 6);

        // 5: reset during the third data bit of 0x55
        push(8'h55);
        push(8'h66);
        repeat (16) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_tx", 32'(tx), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_read_en", 32'(fifo_read_en), 0);
        check("abort_tx_count", 32'(tx_count), 0);   // reset clears the counter
        void'(exp_q.pop_front());                    // 0x55 was popped and is lost
        reset = 1'b1;
        wait_done("done_66");
        @(negedge clk);
        check("after_abort_tx_count", 32'(tx_count), 1);
        check("after_abort_busy", 32'(busy), 0);

        // 6: parity patterns (parity bit checked by the monitor when built in)
        push(8'hA5);
        push(8'h07);
        wait_done("done_a5_2");
        wait_done("done_07");
        @(negedge clk);
        check("par_tx_count", 32'(tx_count), 3);
        check("sb_drained", exp_q.size(), 0);
        check("frames_seen", frame_cnt, 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
